truth_scan_ctrl: RTL and testbench
==================================

TRUTH_SCAN_CTRL -- requirements
Module: truth_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 1, meaning: cycles the input vector is held in APPLY before sampling (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full 8-row scan; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running scan.
REQ-006 sel  input  3  expression select: 0=a x&~(~y|~z), 1=b ~(~x|y)&~z, 2=c ~(~x&y)&z, 3=d ~(x&~y)&z, 4=e (x|y)&(y|~z); 5..7 illegal.
REQ-007 x, y, z  output  1 each  current input vector applied to the evaluator.
REQ-008 s  output  1  evaluator output for current x,y,z and latched sel.
REQ-009 busy  output  1  scan in progress (APPLY or SAMPLE).
REQ-010 done  output  1  one-cycle pulse, scan complete.
REQ-011 table  output  8  captured truth table; bit i = s for {x,y,z}=i.
REQ-012 ones  output  4  count of 1 bits in table (0..8).
REQ-013 err  output  1  start accepted with sel>4; sticky until next start.

Function
REQ-014 States: IDLE, APPLY, SAMPLE, DONE; 3-bit row index idx, dwell counter.
REQ-015 IDLE: start=1 at edge -> APPLY, idx=0, sel latched, table=0, ones=0, err=(sel>4).
REQ-016 start while busy or in DONE shall be ignored; sel changes after acceptance shall have no effect.
REQ-017 APPLY: {x,y,z}=idx; stay DWELL cycles, then -> SAMPLE.
REQ-018 SAMPLE: table[idx] <= s, ones += s; idx=7 -> DONE, else idx+1, -> APPLY.
REQ-019 DONE: done=1 one cycle, -> IDLE; table, ones held until next accepted start.
REQ-020 done shall assert exactly 8*(DWELL+1) rising edges after the edge sampling start.
REQ-021 x,y,z shall be 0 in IDLE and DONE; stable across each APPLY/SAMPLE pair.
REQ-022 Latched sel>4: s=0 for all rows, table=0x00, ones=0, scan timing unchanged.
REQ-023 abort=1 in APPLY/SAMPLE -> IDLE next edge, no done pulse, table/ones keep partial rows; abort in IDLE/DONE ignored.
REQ-024 abort and start same edge in IDLE: start accepted (abort ignored).
REQ-025 idx shall not wrap; row 7 sample always terminates scan.
REQ-026 ones shall never exceed 8; width 4 unsigned.

Reset
REQ-027 rst_n low shall immediately force IDLE, idx=0, dwell counter=0, x=y=z=0, busy=0, done=0, table=0x00, ones=0, err=0.
REQ-028 Reset mid-scan shall discard the scan; first accepted start after rst_n release begins at row 0.

Structure
REQ-029 Shared package holds state enumeration, sel encodings (SEL_A..SEL_E), NUM_ROWS=8.
REQ-030 Combinational evaluator shall be one sub-module, bool_expr_sel (inputs sel,x,y,z; output s); no state in it.
REQ-031 Controller contains no combinational path from start to x,y,z.

Verification
REQ-032 sel=4, DWELL=1, start pulse -> done 16 edges later, table=0xDC, ones=5, err=0.
REQ-033 sel=0,1,2,3 sequential scans -> table=0x80,0x10,0xA2,0x8A; ones=1,1,3,3.
REQ-034 sel=6, start -> err=1, table=0x00, ones=0, done at normal time.
REQ-035 sel=4, abort asserted in row-3 SAMPLE -> no done, busy=0 next cycle, table=0x0C, ones=2.
REQ-036 rst_n low during row 5 APPLY -> all outputs zero immediately; new start (sel=2) -> table=0xA2.
REQ-037 DWELL=3, sel=3 -> done 32 edges after start, table=0x8A; start pulses during busy ignored.

Source files
------------

// File: rtl/truth_scan_ctrl_pkg.sv
// Shared definitions for the truth-table scan controller.
//   state_e       : controller FSM states
//   SEL_A..SEL_E  : expression select encodings (5..7 are illegal)
//   NUM_ROWS      : rows in a 3-input truth table
//   sel_is_legal  : true when a select value names a real expression
package truth_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;

  localparam int NUM_ROWS = 8;

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_E);
  endfunction

endpackage

// File: rtl/truth_scan_ctrl_bool_expr_sel.sv
// Purely combinational evaluator for one of five 3-input boolean expressions.
// Ports:
//   sel   in  3  expression select (SEL_A..SEL_E; anything else yields 0)
//   x,y,z in  1  input vector
//   s     out 1  selected expression evaluated on x,y,z
module bool_expr_sel
  import truth_scan_ctrl_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic       s
);

  always_comb begin
    // NOTE: every path assigns s because of this default, so no latch is inferred.
    s = 1'b0;
    case (sel)
      SEL_A:   s = x & ~(~y | ~z);
      SEL_B:   s = ~(~x | y) & ~z;
      SEL_C:   s = ~(~x & y) & z;
      SEL_D:   s = ~(x & ~y) & z;
      SEL_E:   s = (x | y) & (y | ~z);
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_scan_ctrl.sv
// Truth-table scan controller. On start it walks {x,y,z} through rows 0..7,
// holds each row DWELL cycles, then samples the evaluator output into the
// captured table and accumulates the count of ones.
// Parameters:
//   DWELL        cycles each row is held before sampling (1..15)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        in   request a full scan (accepted only in IDLE)
//   abort        in   stop a running scan, keeping rows captured so far
//   sel[2:0]     in   expression select, latched when start is accepted
//   x, y, z      out  vector applied to the evaluator (0 when not scanning)
//   s            out  evaluator output for x,y,z and latched select
//   busy         out  scan in progress
//   done         out  one-cycle pulse when a scan completes
//   truth_table  out  captured table; bit i is s for {x,y,z} = i
//   ones[3:0]    out  number of set bits in truth_table
//   err          out  last accepted start used an illegal select
module truth_scan_ctrl
  import truth_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] sel,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [3:0] ones,
  output logic       err
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
  localparam logic [2:0] LAST_ROW   = 3'(NUM_ROWS - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q,   idx_d;
  logic [3:0] dwell_q, dwell_d;
  logic [2:0] sel_q,   sel_d;
  logic [7:0] table_q, table_d;
  logic [3:0] ones_q,  ones_d;
  logic       err_q,   err_d;

  logic [2:0] xyz;
  logic       s_int;

  // The applied vector comes only from registered state, so start never
  // reaches x,y,z combinationally, and it reads 0 outside APPLY/SAMPLE.
  assign busy = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
  assign done = (state_q == ST_DONE);
  assign xyz  = busy ? idx_q : 3'b000;
  assign x    = xyz[2];
  assign y    = xyz[1];
  assign z    = xyz[0];
  assign s    = s_int;

  assign truth_table = table_q;
  assign ones        = ones_q;
  assign err         = err_q;

  bool_expr_sel u_eval (
    .sel (sel_q),
    .x   (xyz[2]),
    .y   (xyz[1]),
    .z   (xyz[0]),
    .s   (s_int)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    table_d = table_q;
    ones_d  = ones_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous abort; abort means nothing here.
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = 3'd0;
          dwell_d = 4'd0;
          sel_d   = sel;
          table_d = 8'h00;
          ones_d  = 4'd0;
          err_d   = ~sel_is_legal(sel);
        end
      end

      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          dwell_d = 4'd0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = ST_SAMPLE;
          dwell_d = 4'd0;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        // The row held through SAMPLE is captured even when abort arrives in
        // the same cycle; only the advance to the next row is cancelled.
        table_d[idx_q] = s_int;
        ones_d         = ones_q + {3'b000, s_int};
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (idx_q == LAST_ROW) begin
          state_d = ST_DONE;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_APPLY;
          idx_d   = idx_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      dwell_q <= 4'd0;
      sel_q   <= SEL_A;
      table_q <= 8'h00;
      ones_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_truth_scan_ctrl.sv
// Directed bench for truth_scan_ctrl: one instance with DWELL=1 and one with
// DWELL=3 share clock, reset, select and abort; each has its own start.
module tb_truth_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start1, start3;
  logic       abort;
  logic [2:0] sel;

  logic       x1, y1, z1, s1, busy1, done1, err1;
  logic [7:0] table1;
  logic [3:0] ones1;
  logic       x3, y3, z3, s3, busy3, done3, err3;
  logic [7:0] table3;
  logic [3:0] ones3;

  int n_checks = 0;
  int n_err    = 0;
  int cur_dwell = 1;

  truth_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .sel(sel),
    .x(x1), .y(y1), .z(z1), .s(s1), .busy(busy1), .done(done1),
    .truth_table(table1), .ones(ones1), .err(err1)
  );

  truth_scan_ctrl #(.DWELL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .sel(sel),
    .x(x3), .y(y3), .z(z3), .s(s3), .busy(busy3), .done(done3),
    .truth_table(table3), .ones(ones3), .err(err3)
  );

  logic       busy_m, done_m, err_m;
  logic [2:0] xyz_m;
  logic [7:0] table_m;
  logic [3:0] ones_m;

  assign busy_m  = (cur_dwell == 3) ? busy3  : busy1;
  assign done_m  = (cur_dwell == 3) ? done3  : done1;
  assign err_m   = (cur_dwell == 3) ? err3   : err1;
  assign xyz_m   = (cur_dwell == 3) ? {x3, y3, z3} : {x1, y1, z1};
  assign table_m = (cur_dwell == 3) ? table3 : table1;
  assign ones_m  = (cur_dwell == 3) ? ones3  : ones1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a scan on the selected instance, follow it to done, and check the
  // applied row every cycle, the latency, and that done lasts one cycle while
  // a start held during DONE is ignored. sel is scrambled after acceptance.
  task automatic run_scan(input int d, input logic [2:0] sv, input logic with_abort,
                          input logic poke);
    int lat;
    int exp_lat;
    cur_dwell = d;
    exp_lat   = 8 * (d + 1);
    @(negedge clk);
    sel   = sv;
    abort = with_abort;
    if (d == 3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    sel    = sv ^ 3'b101;
    lat    = 0;
    while (!done_m && lat < 200) begin
      check($sformatf("row_d%0d_sel%0d_t%0d", d, sv, lat), {29'd0, xyz_m},
            32'(lat / (d + 1)));
      if (poke) begin
        start3 = (lat == 5) || (lat == 6);
        start1 = 1'b0;
      end
      tick();
      lat++;
    end
    start3 = 1'b0;
    check($sformatf("latency_d%0d_sel%0d", d, sv), 32'(lat), 32'(exp_lat));
    check("xyz_in_done", {29'd0, xyz_m}, 32'd0);
    if (d == 3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    check("done_one_cycle", {31'd0, done_m}, 32'd0);
    check("start_in_done_ignored", {31'd0, busy_m}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    sel    = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy1}, 32'd0);
    check("rst_done",  {31'd0, done1}, 32'd0);
    check("rst_xyz",   {29'd0, x1, y1, z1}, 32'd0);
    check("rst_table", {24'd0, table1}, 32'h00);
    check("rst_ones",  {28'd0, ones1}, 32'd0);
    check("rst_err",   {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort alone in IDLE does nothing
    @(negedge clk);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_busy", {31'd0, busy1}, 32'd0);

    // sel=4 (e): 0xDC, 5 ones
    run_scan(1, 3'd4, 1'b0, 1'b0);
    check("e_table", {24'd0, table_m}, 32'hDC);
    check("e_ones",  {28'd0, ones_m}, 32'd5);
    check("e_err",   {31'd0, err_m}, 32'd0);

    // Expressions a..d
    run_scan(1, 3'd0, 1'b0, 1'b0);
    check("a_table", {24'd0, table_m}, 32'h80);
    check("a_ones",  {28'd0, ones_m}, 32'd1);
    run_scan(1, 3'd1, 1'b0, 1'b0);
    check("b_table", {24'd0, table_m}, 32'h10);
    check("b_ones",  {28'd0, ones_m}, 32'd1);
    run_scan(1, 3'd2, 1'b0, 1'b0);
    check("c_table", {24'd0, table_m}, 32'hA2);
    check("c_ones",  {28'd0, ones_m}, 32'd3);
    run_scan(1, 3'd3, 1'b0, 1'b0);
    check("d_table", {24'd0, table_m}, 32'h8A);
    check("d_ones",  {28'd0, ones_m}, 32'd3);

    // Illegal select: err set, empty table, normal timing
    run_scan(1, 3'd6, 1'b0, 1'b0);
    check("ill_err",   {31'd0, err_m}, 32'd1);
    check("ill_table", {24'd0, table_m}, 32'h00);
    check("ill_ones",  {28'd0, ones_m}, 32'd0);
    check("ill_err_sticky", {31'd0, err_m}, 32'd1);

    // Next legal start clears err; abort on the same edge as start is ignored
    run_scan(1, 3'd1, 1'b1, 1'b0);
    check("err_cleared", {31'd0, err_m}, 32'd0);
    check("sa_table",    {24'd0, table_m}, 32'h10);

    // Abort during row-3 SAMPLE with sel=4: rows 0..3 kept -> 0x0C, 2 ones
    cur_dwell = 1;
    @(negedge clk);
    sel    = 3'd4;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (7) tick();
    check("abort_row3_xyz",  {29'd0, x1, y1, z1}, 32'd3);
    check("abort_row3_busy", {31'd0, busy1}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  {31'd0, busy1}, 32'd0);
    check("abort_done",  {31'd0, done1}, 32'd0);
    check("abort_table", {24'd0, table1}, 32'h0C);
    check("abort_ones",  {28'd0, ones1}, 32'd2);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        saw_done = saw_done | done1;
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
    end

    // Reset during row-5 APPLY, sel=4: rows 0..4 give 0x1C before reset
    @(negedge clk);
    sel    = 3'd4;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (10) tick();
    check("pre_rst_xyz",   {29'd0, x1, y1, z1}, 32'd5);
    check("pre_rst_table", {24'd0, table1}, 32'h1C);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, busy1}, 32'd0);
    check("mid_rst_xyz",   {29'd0, x1, y1, z1}, 32'd0);
    check("mid_rst_table", {24'd0, table1}, 32'h00);
    check("mid_rst_ones",  {28'd0, ones1}, 32'd0);
    check("mid_rst_done",  {31'd0, done1}, 32'd0);
    check("mid_rst_err",   {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1, 3'd2, 1'b0, 1'b0);
    check("post_rst_table", {24'd0, table_m}, 32'hA2);

    // DWELL=3, sel=3, extra start pulses while busy
    run_scan(3, 3'd3, 1'b0, 1'b1);
    check("d3_table", {24'd0, table_m}, 32'h8A);
    check("d3_ones",  {28'd0, ones_m}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
